sinx_taylor_seq: RTL and testbench

SINX_TAYLOR_SEQ -- requirements
Module: sinx_taylor_seq

---
 rtl/sinx_taylor_seq.sv | 166 ++++++++++++++++
 tb/tb_sinx_taylor_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sinx_taylor_seq.sv
// Sequential Taylor-series sin/cos evaluator for x in [0,1) radians.
// One shared multiplier is reused for x^2, term*x^2 and term*(1/k) steps.
// The result is registered on the first OUT cycle, so out_valid rises
// 2*TERMS edges after acceptance.
module sinx_taylor_seq #(
  parameter int IN_W   = 12,
  parameter int OUT_W  = 6,
  parameter int FRAC_W = 16,
  parameter int TERMS  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  digital,
  input  logic             func_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] analog,
  output logic             busy
);
  localparam int TW = FRAC_W + 1;   // term / xsq width
  localparam int SW = FRAC_W + 3;   // signed sum width
  localparam int PW = 2 * TW;       // product width
  localparam int SH = FRAC_W - OUT_W;
  localparam logic [TW-1:0] ONE     = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [3:0]    TERMS_N = 4'(TERMS);

  typedef enum logic [2:0] {IDLE, SQ, MUL, SCALE, OUT} state_t;

  // Reciprocal tables, index i corresponds to n = i+1.
  function automatic logic [7:0][TW-1:0] mk_recip(input logic cos_f);
    logic [7:0][TW-1:0] t;
    longint den;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      if (cos_f) den = longint'((2*i+1) * (2*i+2));
      else       den = longint'((2*i+2) * (2*i+3));
      t[i] = TW'((longint'(1) <<< FRAC_W) / den);
    end
    return t;
  endfunction

  localparam logic [7:0][TW-1:0] SIN_RECIP = mk_recip(1'b0);
  localparam logic [7:0][TW-1:0] COS_RECIP = mk_recip(1'b1);

  state_t                 state_q, state_d;
  logic [FRAC_W-1:0]      xf_q, xf_d;
  logic [TW-1:0]          xsq_q, xsq_d;
  logic [TW-1:0]          term_q, term_d;
  logic signed [SW-1:0]   sum_q, sum_d;
  logic [3:0]             n_q, n_d;
  logic                   fsel_q, fsel_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_W-1:0]       analog_q, analog_d;

  logic [PW-1:0]          mul_a, mul_b, prod;
  logic [TW-1:0]          prod_sh, recip;
  logic [2:0]             ridx;
  logic [FRAC_W-1:0]      xf_in;
  logic [TW-1:0]          term_in;
  logic [SW-1:0]          sum_sh;
  logic [OUT_W-1:0]       map_code;

  // Shared multiplier operand select, floor after the fraction shift.
  always_comb begin
    ridx  = 3'(n_q - 4'd1);
    recip = fsel_q ? COS_RECIP[ridx] : SIN_RECIP[ridx];
    mul_a = PW'(term_q);
    mul_b = PW'(xsq_q);
    case (state_q)
      SQ:      begin mul_a = PW'(xf_q); mul_b = PW'(xf_q); end
      SCALE:   mul_b = PW'(recip);
      default: ;
    endcase
    prod    = mul_a * mul_b;
    prod_sh = TW'(prod >> FRAC_W);
  end

  // Saturating map of the signed sum onto the output code.
  always_comb begin
    sum_sh = sum_q >> SH;
    if (sum_q[SW-1])                     map_code = '0;
    else if (sum_sh >= SW'(2**OUT_W))    map_code = '1;
    else                                 map_code = OUT_W'(sum_sh);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    xf_d        = xf_q;
    xsq_d       = xsq_q;
    term_d      = term_q;
    sum_d       = sum_q;
    n_d         = n_q;
    fsel_d      = fsel_q;
    out_valid_d = out_valid_q;
    analog_d    = analog_q;
    xf_in       = FRAC_W'(digital) << (FRAC_W - IN_W);
    term_in     = func_sel ? ONE : TW'(xf_in);
    case (state_q)
      IDLE: if (in_valid) begin
        xf_d    = xf_in;
        fsel_d  = func_sel;
        n_d     = 4'd1;
        term_d  = term_in;
        sum_d   = SW'(term_in);
        state_d = SQ;
      end
      SQ: begin
        xsq_d   = prod_sh;
        state_d = (TERMS > 1) ? MUL : OUT;
      end
      MUL: begin
        term_d  = prod_sh;
        state_d = SCALE;
      end
      SCALE: begin
        term_d  = prod_sh;
        sum_d   = n_q[0] ? sum_q - SW'(prod_sh) : sum_q + SW'(prod_sh);
        n_d     = n_q + 4'd1;
        state_d = (n_q + 4'd1 == TERMS_N) ? OUT : MUL;
      end
      OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          analog_d    = map_code;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      xf_q        <= '0;
      xsq_q       <= '0;
      term_q      <= '0;
      sum_q       <= '0;
      n_q         <= '0;
      fsel_q      <= 1'b0;
      out_valid_q <= 1'b0;
      analog_q    <= '0;
    end else begin
      state_q     <= state_d;
      xf_q        <= xf_d;
      xsq_q       <= xsq_d;
      term_q      <= term_d;
      sum_q       <= sum_d;
      n_q         <= n_d;
      fsel_q      <= fsel_d;
      out_valid_q <= out_valid_d;
      analog_q    <= analog_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign analog    = analog_q;
endmodule

// File: tb/tb_sinx_taylor_seq.sv
// Bench for sinx_taylor_seq: vector table + scoreboard, handshake and
// reset corner sequences, plus a TERMS=1 instance.
module tb_sinx_taylor_seq;
  localparam int T = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, func_sel, out_ready;
  logic [11:0] digital;
  logic       in_ready, out_valid, busy;
  logic [5:0] analog;

  logic       iv1, fs1, or1, ir1, ov1, busy1;
  logic [11:0] dig1;
  logic [5:0] an1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { int exp; int acc; } sb_t;
  typedef struct { int dig; bit fs; int exp; } vec_t;
  sb_t  q[$];
  vec_t vecs[12];

  sinx_taylor_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .digital(digital), .func_sel(func_sel), .out_valid(out_valid),
    .out_ready(out_ready), .analog(analog), .busy(busy));

  sinx_taylor_seq #(.TERMS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .digital(dig1), .func_sel(fs1), .out_valid(ov1),
    .out_ready(or1), .analog(an1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the series evaluated as described, in wide integers.
  function automatic int model(input int dig, input bit fs, input int terms);
    longint one, xf, xsq, term, sum, recip, sh;
    one  = 64'd1 << 16;
    xf   = longint'(dig) << 4;
    xsq  = (xf * xf) >> 16;
    term = fs ? one : xf;
    sum  = term;
    for (int n = 1; n < terms; n++) begin
      term  = (term * xsq) >> 16;
      recip = fs ? one / longint'((2*n-1)*(2*n)) : one / longint'((2*n)*(2*n+1));
      term  = (term * recip) >> 16;
      sum   = (n % 2 == 1) ? sum - term : sum + term;
    end
    if (sum < 0) return 0;
    sh = sum >>> 10;
    if (sh >= 64) return 63;
    return int'(sh);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: latency on out_valid rise, value on handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (q.size() == 0) chk("spurious_out_valid", 1, 0);
      else chk("latency", cyc - q[0].acc, 2*T);
    end
    if (out_valid && out_ready && q.size() > 0) begin
      sb_t e;
      e = q.pop_front();
      chk("analog", int'(analog), e.exp);
    end
    prev_ov = out_valid;
  end

  task automatic send(input int dig, input bit fs, input int exp);
    int n = 0;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1; digital = 12'(dig); func_sel = fs;
    @(posedge clk); #1;
    q.push_back('{exp: exp, acc: cyc});
    in_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(q.size() == 0 && in_ready) && n < 400) begin @(posedge clk); #1; n++; end
    if (n >= 400) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
  endtask

  initial begin
    vec_t v;
    sb_t  e;
    int   held, n, seen;
    rst = 1'b1; in_valid = 1'b0; digital = '0; func_sel = 1'b0; out_ready = 1'b1;
    iv1 = 1'b0; dig1 = '0; fs1 = 1'b0; or1 = 1'b1;

    vecs[0] = '{0,    1'b0, 0};
    vecs[1] = '{0,    1'b1, 63};
    vecs[2] = '{2048, 1'b1, 56};
    vecs[3] = '{2048, 1'b0, 30};
    vecs[4] = '{4095, 1'b0, 53};
    vecs[5] = '{4095, 1'b1, model(4095, 1'b1, T)};
    for (int i = 6; i < 12; i++) begin
      v.dig = int'($urandom_range(0, 4095));
      v.fs  = 1'($urandom_range(0, 1));
      v.exp = model(v.dig, v.fs, T);
      vecs[i] = v;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_analog", int'(analog), 0);

    // First edge after reset release accepts.
    rst = 1'b0; in_valid = 1'b1; digital = 12'd2048; func_sel = 1'b0;
    @(posedge clk); #1;
    chk("accept_after_rst", int'(busy), 1);
    q.push_back('{exp: 30, acc: cyc});
    in_valid = 1'b0;
    wait_done();

    // Vector table.
    for (int i = 0; i < 12; i++) send(vecs[i].dig, vecs[i].fs, vecs[i].exp);
    wait_done();

    // Back-pressure in OUT with a new request waiting.
    out_ready = 1'b0;
    send(1000, 1'b0, model(1000, 1'b0, T));
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("ov_wait", int'(out_valid), 1);
    held = int'(analog);
    in_valid = 1'b1; digital = 12'd2048; func_sel = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_analog", int'(analog), held);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_idle", int'(in_ready), 1);
    chk("release_ov", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("next_accept", int'(busy), 1);
    q.push_back('{exp: 56, acc: cyc});
    in_valid = 1'b0;
    wait_done();

    // Reset pulse while in MUL.
    send(2048, 1'b0, 30);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_analog", int'(analog), 0);
    seen = 0;
    for (int k = 0; k < 3*T; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("midrst_no_ov", seen, 0);
    send(2048, 1'b0, 30);
    wait_done();

    // TERMS=1 instance.
    @(posedge clk); #1;
    iv1 = 1'b1; dig1 = 12'd2048; fs1 = 1'b0;
    @(posedge clk); #1;
    iv1 = 1'b0;
    n = 0;
    while (!ov1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("t1_latency", n, 2);
    chk("t1_analog", int'(an1), 32);
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
